mem_wb_skid_stage: RTL and testbench
====================================

# mem_wb_skid_stage

Parametrised successor to the fixed MEM/WB register: a single pipeline stage carrying LANES data lanes, the instruction word and write-back control, with valid/ready handshaking, a two-entry skid buffer, flush-to-bubble and a saturating stall counter. Sits between the MEM stage and the WB/register-file write logic. It also serves any other stage boundary that needs backpressure. Full throughput of one transfer per cycle is sustained while the consumer is ready.

## Interface
- DATA_W, 8, bits per data lane
- LANES, 3, number of data lanes (mem_out, alu_out, shift_out in the default build)
- INSTR_W, 19, instruction word width
- CTRL_W, 2, write-back control width (reg_write_mux)
- CNT_W, 16, stall counter width

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  producer has a word
- in_ready  out  1  stage can accept; registered (not combinational from out_ready)
- in_data  in  LANES*DATA_W  lane 0 in bits [DATA_W-1:0]
- in_instr  in  INSTR_W  instruction word
- in_ctrl  in  CTRL_W  write-back control
- out_valid  out  1  main entry holds a word
- out_ready  in  1  consumer accepts
- out_data  out  LANES*DATA_W  main entry data
- out_instr  out  INSTR_W  main entry instruction
- out_ctrl  out  CTRL_W  main entry control
- flush  in  1  discard all contents, inject bubble
- clear_stats  in  1  zero stall counter
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Two storage entries: MAIN (drives outputs) and SKID. States: EMPTY (none valid), ONE (MAIN valid), FULL (MAIN and SKID valid).
- out_valid = state != EMPTY. in_ready = state != FULL, registered alongside state.
- acc_in = in_valid & in_ready; acc_out = out_valid & out_ready.
- EMPTY: acc_in -> ONE, MAIN <= input.
- ONE: acc_in & acc_out -> ONE, MAIN <= input. acc_in only -> FULL, SKID <= input. acc_out only -> EMPTY, MAIN <= 0. Neither -> ONE, hold.
- FULL: acc_out -> ONE, MAIN <= SKID, SKID <= 0. Else hold. (acc_in impossible.)
- Bubble rule: any entry not valid holds all-zero data, instr and ctrl, so out_ctrl=0 (no register write) whenever out_valid=0.
- Priority: reset > flush > normal transfer.
- flush: state <= EMPTY, MAIN and SKID <= 0, in_ready <= 1. A word presented with in_valid during the flush cycle is dropped. acc_out in that cycle counts as a completed transfer for the consumer.
- Never overwrite a valid entry. Never duplicate or reorder words; output order = acceptance order.
- stall_cnt: +1 each cycle out_valid & ~out_ready. Saturates at 2^CNT_W-1, no wrap. clear_stats zeroes it with priority over increment. flush does not affect it.

## Timing
- Reset values: state EMPTY, in_ready=1, out_valid=0, out_data=0, out_instr=0, out_ctrl=0, stall_cnt=0.
- Reset asserted mid-transfer discards both entries on the next edge. In-flight words are lost.
- Latency: word accepted at edge N appears on outputs after edge N with out_valid=1, i.e. 1 cycle.
- in_ready falls the cycle after SKID fills. It rises the cycle after a FULL-state drain.
- out_ready low for k cycles with in_valid high: at most 2 words absorbed. No loss.
- All outputs are register-driven. There is no combinational path from any input to any output.

## Test plan
- Reset then stream 10 words with out_ready=1 and in_valid=1 → out_valid from cycle 1, one word/cycle in order, in_ready stays 1, stall_cnt=0.
- Fill then backpressure: send A, B, C while out_ready=0 → A on outputs, B in SKID, in_ready=0 after B, C held by producer. Raise out_ready → A, B, C delivered in order, stall_cnt equals the stalled cycles.
- Flush while FULL with in_valid=1 → next cycle out_valid=0, out_ctrl=0, out_instr=0, in_ready=1. The flushed and presented words never appear.
- Drain to empty: single word X, out_ready=1 → X for one cycle, then out_valid=0 with all outputs zero.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt stops at 15. clear_stats → 0 next cycle.
- Reset mid-stream while FULL → all outputs zero and in_ready=1 next cycle. Subsequent word Y emerges alone one cycle after acceptance.

Source files
------------

// File: rtl/mem_wb_skid_stage.sv
// Purpose: MEM/WB pipeline register with a two-entry skid buffer (MAIN drives the outputs, SKID absorbs one extra word), flush-to-bubble and a saturating stall counter.
// Latency: a word accepted at edge N is on the outputs after edge N (1 cycle). One transfer per cycle is sustained while out_ready=1.
// Backpressure: in_ready is registered and drops only once SKID holds a word, so at most two words are absorbed while out_ready is low. Nothing is lost.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   producer handshake; in_data/in_instr/in_ctrl carry the word
//   out_valid/out_ready consumer handshake; out_data/out_instr/out_ctrl come from MAIN
//   flush               empties both entries and injects a bubble (the word presented in that cycle is dropped)
//   clear_stats         zeroes stall_cnt, taking priority over an increment
//   stall_cnt           cycles with out_valid=1 and out_ready=0, saturating
module mem_wb_skid_stage #(
    parameter int DATA_W  = 8,
    parameter int LANES   = 3,
    parameter int INSTR_W = 19,
    parameter int CTRL_W  = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [INSTR_W-1:0]      in_instr,
    input  logic [CTRL_W-1:0]       in_ctrl,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [INSTR_W-1:0]      out_instr,
    output logic [CTRL_W-1:0]       out_ctrl,
    input  logic                    flush,
    input  logic                    clear_stats,
    output logic [CNT_W-1:0]        stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                    state;
    logic [LANES*DATA_W-1:0]   skid_data;
    logic [INSTR_W-1:0]        skid_instr;
    logic [CTRL_W-1:0]         skid_ctrl;

    logic acc_in;
    logic acc_out;

    // Both handshake sides look only at registered flags, so there is no
    // combinational path from any input to any output.
    assign acc_in  = in_valid & in_ready;
    assign acc_out = out_valid & out_ready;

    // MAIN is the output register itself. out_valid and in_ready are kept as
    // registered copies of (state != EMPTY) and (state != FULL).
    // Empty entries are always zeroed, so out_ctrl=0 (no register write)
    // whenever out_valid=0.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state      <= ST_EMPTY;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            out_data   <= '0;
            out_instr  <= '0;
            out_ctrl   <= '0;
            skid_data  <= '0;
            skid_instr <= '0;
            skid_ctrl  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc_in) begin
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                        out_instr <= in_instr;
                        out_ctrl  <= in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (acc_in && acc_out) begin
                        out_data  <= in_data;
                        out_instr <= in_instr;
                        out_ctrl  <= in_ctrl;
                    end else if (acc_in) begin
                        // Consumer stalled: park the new word behind MAIN.
                        state      <= ST_FULL;
                        in_ready   <= 1'b0;
                        skid_data  <= in_data;
                        skid_instr <= in_instr;
                        skid_ctrl  <= in_ctrl;
                    end else if (acc_out) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_instr <= '0;
                        out_ctrl  <= '0;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (acc_out) begin
                        state      <= ST_ONE;
                        in_ready   <= 1'b1;
                        out_data   <= skid_data;
                        out_instr  <= skid_instr;
                        out_ctrl   <= skid_ctrl;
                        skid_data  <= '0;
                        skid_instr <= '0;
                        skid_ctrl  <= '0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    out_data  <= '0;
                    out_instr <= '0;
                    out_ctrl  <= '0;
                end
            endcase
        end
    end

    // The stall counter saturates instead of wrapping, and flush leaves it
    // untouched so that stalls seen before a flush are still reported.
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
module tb_mem_wb_skid_stage;

    localparam int DATA_W  = 8;
    localparam int LANES   = 3;
    localparam int INSTR_W = 19;
    localparam int CTRL_W  = 2;
    localparam int CNT_W   = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic [INSTR_W-1:0]      in_instr;
    logic [CTRL_W-1:0]       in_ctrl;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic [INSTR_W-1:0]      out_instr;
    logic [CTRL_W-1:0]       out_ctrl;
    logic                    flush;
    logic                    clear_stats;
    logic [CNT_W-1:0]        stall_cnt;

    int checks = 0;
    int errors = 0;

    mem_wb_skid_stage #(
        .DATA_W(DATA_W), .LANES(LANES), .INSTR_W(INSTR_W),
        .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_instr(in_instr), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_instr(out_instr), .out_ctrl(out_ctrl),
        .flush(flush), .clear_stats(clear_stats), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Word k: lanes A0+k / B0+k / C0+k, instr 0x100+k, ctrl cycles 1..3.
    function automatic logic [23:0] wd(input int k);
        wd = {8'(8'hA0 + k), 8'(8'hB0 + k), 8'(8'hC0 + k)};
    endfunction
    function automatic logic [18:0] wi(input int k);
        wi = 19'(19'h100 + k);
    endfunction
    function automatic logic [1:0] wc(input int k);
        wc = 2'(k % 3 + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present(input int k);
        in_valid = 1'b1;
        in_data  = wd(k);
        in_instr = wi(k);
        in_ctrl  = wc(k);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = '0;
        in_instr = '0;
        in_ctrl  = '0;
    endtask

    task automatic chk_word(input string tag, input int k);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"},  64'(out_data),  64'(wd(k)));
        chk({tag, "_instr"}, 64'(out_instr), 64'(wi(k)));
        chk({tag, "_ctrl"},  64'(out_ctrl),  64'(wc(k)));
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"},  64'(out_data),  64'd0);
        chk({tag, "_instr"}, 64'(out_instr), 64'd0);
        chk({tag, "_ctrl"},  64'(out_ctrl),  64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        clear_stats = 1'b0;
        out_ready   = 1'b0;
        idle_in();

        // Reset values
        tick();
        tick();
        chk_bubble("rst");
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        reset = 1'b0;

        // Streaming: 10 words, one per cycle, in order
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            present(i);
            tick();
            chk_word($sformatf("stream%0d", i), i);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
        end
        idle_in();
        tick();
        chk_bubble("stream_end");
        chk("stream_stall", 64'(stall_cnt), 64'd0);

        // Drain to empty: single word X
        present(20);
        tick();
        chk_word("drainX", 20);
        idle_in();
        tick();
        chk_bubble("drain_empty");

        // Fill then backpressure: A, B, C with out_ready low
        out_ready = 1'b0;
        present(30);               // A
        tick();
        chk_word("bpA", 30);
        chk("bpA_in_ready", 64'(in_ready), 64'd1);
        chk("bpA_stall", 64'(stall_cnt), 64'd0);
        present(31);               // B goes to SKID
        tick();
        chk_word("bpA_hold1", 30);
        chk("bpB_in_ready", 64'(in_ready), 64'd0);
        chk("bpB_stall", 64'(stall_cnt), 64'd1);
        present(32);               // C held by producer
        tick();
        chk_word("bpA_hold2", 30);
        chk("bpC_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("bp_stall3", 64'(stall_cnt), 64'd3);
        out_ready = 1'b1;
        tick();
        chk_word("bp_outB", 31);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        tick();                    // C accepted while B leaves
        chk_word("bp_outC", 32);
        idle_in();
        tick();
        chk_bubble("bp_end");
        chk("bp_stall_final", 64'(stall_cnt), 64'd3);

        // Flush while FULL with a word presented
        out_ready = 1'b0;
        present(40);
        tick();
        present(41);
        tick();
        chk("fl_full", 64'(in_ready), 64'd0);
        present(42);
        flush = 1'b1;
        tick();
        chk_bubble("flush");
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_keeps_stall", 64'(stall_cnt), 64'd5);
        flush = 1'b0;
        idle_in();
        out_ready = 1'b1;
        tick();
        chk_bubble("flush_after");
        clear_stats = 1'b1;
        tick();
        chk("clear_stats", 64'(stall_cnt), 64'd0);
        clear_stats = 1'b0;

        // Saturation: 20 stalled cycles on a 4-bit counter
        out_ready = 1'b0;
        present(50);
        tick();
        chk_word("satS", 50);
        idle_in();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("sat_14", 64'(stall_cnt), 64'd14);
        end
        chk("sat_15", 64'(stall_cnt), 64'd15);
        clear_stats = 1'b1;        // wins over the increment still pending
        tick();
        chk("sat_clear", 64'(stall_cnt), 64'd0);
        clear_stats = 1'b0;

        // Reset mid-stream while FULL
        present(51);
        tick();
        chk("rs_full", 64'(in_ready), 64'd0);
        idle_in();
        reset = 1'b1;
        tick();
        chk_bubble("rs");
        chk("rs_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        out_ready = 1'b1;
        present(60);               // Y
        tick();
        chk_word("rsY", 60);
        idle_in();
        tick();
        chk_bubble("rsY_alone");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
